// File: rtl/rw_stream_pkg.sv
// Shared types and constants for the 1-bit resumption-device stream blocks.
// Contents:
//   rw_drv_state_t   - driver FSM states (IDLE, SHIFT, DRAIN, HOLD)
//   RW_MAX_CAP_DELAY - largest supported device response latency in cycles
//   cnt_w()          - width of a counter that must hold the value 'width'
package rw_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } rw_drv_state_t;

  localparam int RW_MAX_CAP_DELAY = 3;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/rw_bit_capture.sv
// Response capture for a 1-bit device stream: delays the "bit presented"
// strobe by CAP_DELAY cycles so it lines up with the device answer, then
// deserializes dut_out into a WIDTH-bit word in the same bit order as sent.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bit_strobe high in every cycle a serial bit is on the device input
//   dut_out    serial bit from the device output
//   cap_data   captured word (registered)
module rw_bit_capture #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CAP_DELAY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_strobe,
  input  logic             dut_out,
  output logic [WIDTH-1:0] cap_data
);

  logic             take_s;
  logic [WIDTH-1:0] cap_data_q, cap_data_d;

  // The strobe, not the data, is delayed: the device answer for bit k is
  // already on dut_out CAP_DELAY cycles after bit k went out.
  generate
    if (CAP_DELAY == 0) begin : g_nodly
      assign take_s = bit_strobe;
    end else begin : g_dly
      logic [CAP_DELAY-1:0] strobe_q, strobe_d;

      // Strobe delay line next value.
      always_comb begin
        strobe_d = (strobe_q << 1'b1) | CAP_DELAY'(bit_strobe);
      end

      // Strobe delay line register.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          strobe_q <= '0;
        end else begin
          strobe_q <= strobe_d;
        end
      end

      assign take_s = strobe_q[CAP_DELAY-1];
    end
  endgenerate

  // Deserializer next value: the first response must end up in the position
  // the first transmitted bit came from.
  always_comb begin
    cap_data_d = cap_data_q;
    if (take_s) begin
      if (LSB_FIRST) begin
        cap_data_d = (cap_data_q >> 1'b1) | (WIDTH'(dut_out) << (WIDTH - 1));
      end else begin
        cap_data_d = (cap_data_q << 1'b1) | WIDTH'(dut_out);
      end
    end else begin
      cap_data_d = cap_data_q;
    end
  end

  // Deserializer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_data_q <= '0;
    end else begin
      cap_data_q <= cap_data_d;
    end
  end

  assign cap_data = cap_data_q;

endmodule

// File: rtl/rw_bitstream_driver.sv
// Transmit side of the 1-bit resumption-device stream interface. Accepts
// words over valid/ready, shifts them out one bit per clock on dut_in, and
// returns the device's serial answer as a word over valid/ready.
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   in_data/in_valid/in_ready    word input handshake
//   dut_in               registered serial bit to the device
//   dut_out              serial bit from the device
//   out_data/out_valid/out_ready response word handshake (held until taken)
//   busy                 high while shifting or draining responses
module rw_bitstream_driver
  import rw_stream_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   LSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0,
  parameter int   CAP_DELAY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dut_in,
  input  logic             dut_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  // One counter serves both the bit count and the drain count.
  localparam int CNT_W = (cnt_w(WIDTH) > cnt_w(RW_MAX_CAP_DELAY)) ?
                         cnt_w(WIDTH) : cnt_w(RW_MAX_CAP_DELAY);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'((CAP_DELAY > 0) ? CAP_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  rw_drv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic             dut_in_q, dut_in_d;
  logic             ready_en_q, ready_en_d;
  logic             accept_s, last_bit_s, last_drain_s;

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] next_tx(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? (v >> 1'b1) : (v << 1'b1);
  endfunction

  assign accept_s     = in_valid & in_ready;
  assign last_bit_s   = (cnt_q == LAST_BIT);
  assign last_drain_s = (cnt_q == LAST_DRAIN);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_q       <= '0;
      dut_in_q   <= IDLE_BIT;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      dut_in_q   <= dut_in_d;
      ready_en_q <= ready_en_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = SHIFT;
        else          state_d = IDLE;
      end
      SHIFT: begin
        if (last_bit_s) state_d = (CAP_DELAY > 0) ? DRAIN : HOLD;
        else            state_d = SHIFT;
      end
      DRAIN: begin
        if (last_drain_s) state_d = HOLD;
        else              state_d = DRAIN;
      end
      HOLD: begin
        // Handoff and the next load share one edge, so streaming has no gap.
        if (out_ready) state_d = accept_s ? SHIFT : IDLE;
        else           state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. ready_en_q keeps in_ready low until the first edge out of reset.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:  in_ready = ready_en_q;
      SHIFT: busy = 1'b1;
      DRAIN: busy = 1'b1;
      HOLD: begin
        in_ready  = ready_en_q & out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Transmit shift register, serial output bit and bit/drain counter.
  always_comb begin
    cnt_d      = '0;
    tx_d       = tx_q;
    dut_in_d   = IDLE_BIT;
    ready_en_d = 1'b1;
    if (accept_s) begin
      tx_d     = next_tx(in_data);
      dut_in_d = first_bit(in_data);
      cnt_d    = '0;
    end else if (state_q == SHIFT) begin
      if (!last_bit_s) begin
        cnt_d    = cnt_q + CNT_ONE;
        dut_in_d = first_bit(tx_q);
        tx_d     = next_tx(tx_q);
      end else begin
        cnt_d    = '0;
        dut_in_d = IDLE_BIT;
        tx_d     = tx_q;
      end
    end else if (state_q == DRAIN) begin
      cnt_d = last_drain_s ? '0 : (cnt_q + CNT_ONE);
    end else begin
      cnt_d = '0;
    end
  end

  rw_bit_capture #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST),
    .CAP_DELAY (CAP_DELAY)
  ) u_capture (
    .clk        (clk),
    .rst        (rst),
    .bit_strobe (state_q == SHIFT),
    .dut_out    (dut_out),
    .cap_data   (out_data)
  );

  assign dut_in = dut_in_q;

endmodule

// File: tb/tb_rw_bitstream_driver.sv
// Self-checking bench for rw_bitstream_driver. Several configurations run in
// parallel, each against a simple device model (echo or inverter with a
// configurable latency). Expected serial bits and response words come from
// the word itself: bit order per LSB_FIRST, response = word or ~word.
module tb_rw_bitstream_driver;

  localparam int NCFG = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic check_eq(input int cfg, input string tag,
                          input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int   W   = (g == 3) ? 1 : (g == 4) ? 5 : 8;
    localparam bit   LSB = (g == 1 || g == 4) ? 1'b0 : 1'b1;
    localparam logic IDL = (g == 3 || g == 4) ? 1'b1 : 1'b0;
    localparam int   CAP = (g == 2) ? 2 : (g == 3) ? 3 : (g == 4) ? 1 : 0;
    localparam bit   INV = (g == 1 || g == 3) ? 1'b1 : 1'b0;

    logic         rst, in_valid, in_ready, dut_in, dut_out;
    logic         out_valid, out_ready, busy;
    logic [W-1:0] in_data, out_data;

    rw_bitstream_driver #(
      .WIDTH(W), .LSB_FIRST(LSB), .IDLE_BIT(IDL), .CAP_DELAY(CAP)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .dut_in(dut_in), .dut_out(dut_out),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy)
    );

    // Device model: answers each input bit CAP cycles later, optionally inverted.
    if (CAP == 0) begin : g_dev0
      assign dut_out = dut_in ^ INV;
    end else begin : g_devn
      logic [CAP-1:0] pipe = '0;
      always @(posedge clk) pipe <= (pipe << 1) | CAP'(dut_in);
      assign dut_out = pipe[CAP-1] ^ INV;
    end

    initial begin : stim
      logic [W-1:0] word, expw;
      logic         exp_bit;
      bit           b2b, rst_hit;
      int           waitc, stall;

      rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq(g, "rst_in_ready",  32'(in_ready),  32'd0);
      check_eq(g, "rst_out_valid", 32'(out_valid), 32'd0);
      check_eq(g, "rst_out_data",  32'(out_data),  32'd0);
      check_eq(g, "rst_busy",      32'(busy),      32'd0);
      check_eq(g, "rst_dut_in",    32'(dut_in),    32'(IDL));
      rst = 1'b1;
      #1;
      check_eq(g, "ready_pre_edge", 32'(in_ready), 32'd0);
      @(negedge clk); #1;
      check_eq(g, "ready_after_rst", 32'(in_ready), 32'd1);

      b2b = 1'b0;
      for (int n = 0; n < 12; n++) begin
        word = W'($urandom);
        if (n == 0) begin
          case (g)
            0: word = W'(8'hA5);
            1: word = W'(8'h81);
            2: word = W'(8'h3C);
            default: word = W'($urandom);
          endcase
        end
        if (g == 0 && n >= 1 && n <= 3) word = W'(n);
        if (g == 0 && n == 4) word = '1;

        in_valid = 1'b1; in_data = word;
        #1;
        waitc = 0;
        while (!in_ready && waitc < 40) begin
          @(negedge clk); #1;
          waitc++;
        end
        check_eq(g, "accept_seen", 32'(in_ready), 32'd1);
        if (b2b) check_eq(g, "b2b_gap", 32'(waitc), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_data = ~word; out_ready = 1'b0;

        rst_hit = 1'b0;
        for (int k = 0; k < W; k++) begin
          if (k > 0) @(negedge clk);
          #1;
          if (g == 0 && n == 4 && k == 4) begin
            rst_hit = 1'b1;
            break;
          end
          exp_bit = LSB ? word[k] : word[W-1-k];
          check_eq(g, "serial_bit",   32'(dut_in),    32'(exp_bit));
          check_eq(g, "shift_busy",   32'(busy),      32'd1);
          check_eq(g, "shift_nvalid", 32'(out_valid), 32'd0);
          check_eq(g, "shift_nready", 32'(in_ready),  32'd0);
        end

        if (rst_hit) begin
          rst = 1'b0;
          #1;
          check_eq(g, "midrst_dut_in", 32'(dut_in),    32'(IDL));
          check_eq(g, "midrst_busy",   32'(busy),      32'd0);
          check_eq(g, "midrst_nvalid", 32'(out_valid), 32'd0);
          repeat (2) @(negedge clk);
          rst = 1'b1;
          @(negedge clk); #1;
          check_eq(g, "midrst_after_nvalid", 32'(out_valid), 32'd0);
          check_eq(g, "midrst_after_ready",  32'(in_ready),  32'd1);
          b2b = 1'b0;
          continue;
        end

        for (int j = 0; j < CAP; j++) begin
          @(negedge clk); #1;
          check_eq(g, "drain_idle",   32'(dut_in),    32'(IDL));
          check_eq(g, "drain_busy",   32'(busy),      32'd1);
          check_eq(g, "drain_nvalid", 32'(out_valid), 32'd0);
        end

        @(negedge clk); #1;
        expw = INV ? ~word : word;
        check_eq(g, "valid_latency", 32'(out_valid), 32'd1);
        check_eq(g, "out_data",      32'(out_data),  32'(expw));
        check_eq(g, "hold_busy",     32'(busy),      32'd0);
        check_eq(g, "hold_dut_in",   32'(dut_in),    32'(IDL));
        check_eq(g, "hold_nready",   32'(in_ready),  32'd0);

        stall = $urandom_range(0, 3);
        if (g == 0 && n < 3) stall = 0;
        if (g == 0 && n == 5) stall = 20;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk); #1;
          check_eq(g, "stall_valid",  32'(out_valid), 32'd1);
          check_eq(g, "stall_data",   32'(out_data),  32'(expw));
          check_eq(g, "stall_nready", 32'(in_ready),  32'd0);
          check_eq(g, "stall_dut_in", 32'(dut_in),    32'(IDL));
        end

        b2b = ($urandom_range(0, 1) == 1);
        if (g == 0 && n < 3) b2b = 1'b1;
        out_ready = 1'b1;
        if (!b2b) begin
          @(negedge clk); #1;
          check_eq(g, "exit_nvalid", 32'(out_valid), 32'd0);
          check_eq(g, "idle_ready",  32'(in_ready),  32'd1);
          out_ready = 1'b0;
        end
      end

      in_valid = 1'b0;
      out_ready = 1'b0;
      done_cnt++;
    end
  end

  initial begin
    for (int c = 0; c < 30000 && done_cnt < NCFG; c++) @(posedge clk);
    check_eq(-1, "all_done", 32'(done_cnt), 32'(NCFG));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
